// File: rtl/pulse_gen_pkg.sv
// Shared opcodes, command/report field positions and FSM states for the
// pulse train generator.
package pulse_gen_pkg;

    // Command opcodes carried in cmd_in[63:62]
    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_START = 2'b01;
    localparam logic [1:0] OP_STOP  = 2'b10;
    localparam logic [1:0] OP_LEVEL = 2'b11;

    // Command field offsets
    localparam int OPCODE_LSB   = 62;
    localparam int HIGH_LEN_LSB = 32;
    localparam int LOW_LEN_LSB  = 16;
    localparam int PCOUNT_LSB   = 0;
    localparam int LEVEL_BIT    = 0;

    // Report word layout
    localparam int RPT_TS_LSB    = 64;
    localparam int RPT_ZERO_BIT  = 50;
    localparam int RPT_REJ_BIT   = 49;
    localparam int RPT_ABORT_BIT = 48;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/pulse_gen_phase_timer.sv
// Loadable down-counter timing one HIGH or LOW phase. Loading len arms the
// timer for len cycles (len=0 behaves as 1); expire is high in the last one.
module pulse_phase_timer
    import pulse_gen_pkg::*;
#(
    parameter int PERIOD_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [PERIOD_WIDTH-1:0] len,
    output logic                    expire
);

    logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d;

    // Load len-1 (zero-length clamps to one cycle), else count down to 0 and hold
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = (len == '0) ? '0 : len - PERIOD_WIDTH'(1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - PERIOD_WIDTH'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign expire = (cnt_q == '0);

endmodule

// File: rtl/pulse_train_generator.sv
// Timed pulse train generator: accepts START/STOP/LEVEL commands from the GPO
// core, drives a registered pulse train and writes a 128-bit completion report
// toward the RTI FIFO.
module pulse_train_generator
    import pulse_gen_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int PERIOD_WIDTH = 16
) (
    input  logic         s_axi_aclk,
    input  logic         s_axi_aresetn,
    input  logic [63:0]  cmd_in,
    input  logic         valid,
    input  logic [63:0]  counter,
    output logic         output_sig,
    output logic         busy,
    output logic         write,
    output logic [127:0] report_out
);

    // Command decode
    logic [1:0]              opcode;
    logic                    cmd_start, cmd_stop, cmd_level;
    logic [PERIOD_WIDTH-1:0] cmd_high, cmd_low;
    logic [DATA_WIDTH-1:0]   cmd_pcount;
    logic                    unused_cmd;

    assign opcode     = cmd_in[OPCODE_LSB +: 2];
    assign cmd_start  = valid && (opcode == OP_START);
    assign cmd_stop   = valid && (opcode == OP_STOP);
    assign cmd_level  = valid && (opcode == OP_LEVEL);
    assign cmd_high   = cmd_in[HIGH_LEN_LSB +: PERIOD_WIDTH];
    assign cmd_low    = cmd_in[LOW_LEN_LSB +: PERIOD_WIDTH];
    assign cmd_pcount = cmd_in[PCOUNT_LSB +: DATA_WIDTH];
    assign unused_cmd = ^cmd_in;

    // State
    state_t                  state_q, state_d;
    logic                    idle_level_q, idle_level_d;
    logic [PERIOD_WIDTH-1:0] high_len_q, high_len_d;
    logic [PERIOD_WIDTH-1:0] low_len_q, low_len_d;
    logic [DATA_WIDTH-1:0]   pcount_q, pcount_d;
    logic [DATA_WIDTH-1:0]   emitted_q, emitted_d;
    logic [63:0]             start_ts_q, start_ts_d;
    logic                    rejected_q, rejected_d;
    logic                    out_q, out_d;
    logic                    busy_q, busy_d;
    logic                    write_q, write_d;
    logic [127:0]            report_q, report_d;

    // Phase timer interface
    logic                    tmr_load;
    logic [PERIOD_WIDTH-1:0] tmr_len;
    logic                    tmr_expire;

    logic done_now, zero_flag, abort_flag;

    pulse_phase_timer #(.PERIOD_WIDTH(PERIOD_WIDTH)) u_timer (
        .clk    (s_axi_aclk),
        .rst_n  (s_axi_aresetn),
        .load   (tmr_load),
        .len    (tmr_len),
        .expire (tmr_expire)
    );

    // FSM, command handling and report assembly
    always_comb begin
        state_d      = state_q;
        idle_level_d = idle_level_q;
        high_len_d   = high_len_q;
        low_len_d    = low_len_q;
        pcount_d     = pcount_q;
        emitted_d    = emitted_q;
        start_ts_d   = start_ts_q;
        rejected_d   = rejected_q;
        report_d     = report_q;
        write_d      = 1'b0;
        tmr_load     = 1'b0;
        tmr_len      = high_len_q;
        done_now     = 1'b0;
        zero_flag    = 1'b0;
        abort_flag   = 1'b0;

        if (cmd_level) idle_level_d = cmd_in[LEVEL_BIT];

        case (state_q)
            IDLE, DONE: begin
                if (state_q == DONE) state_d = IDLE;
                if (cmd_start) begin
                    start_ts_d = counter;
                    high_len_d = cmd_high;
                    low_len_d  = cmd_low;
                    pcount_d   = cmd_pcount;
                    emitted_d  = '0;
                    if (cmd_pcount == '0) begin
                        state_d   = DONE;
                        done_now  = 1'b1;
                        zero_flag = 1'b1;
                    end else begin
                        state_d  = HIGH;
                        tmr_load = 1'b1;
                        tmr_len  = cmd_high;
                    end
                end
            end
            HIGH: begin
                // STOP wins over a coinciding phase end: that pulse is not counted
                if (cmd_stop) begin
                    state_d    = DONE;
                    done_now   = 1'b1;
                    abort_flag = 1'b1;
                end else if (tmr_expire) begin
                    state_d   = LOW;
                    emitted_d = emitted_q + DATA_WIDTH'(1);
                    tmr_load  = 1'b1;
                    tmr_len   = low_len_q;
                end
            end
            LOW: begin
                if (cmd_stop) begin
                    state_d    = DONE;
                    done_now   = 1'b1;
                    abort_flag = 1'b1;
                end else if (tmr_expire) begin
                    if (emitted_q == pcount_q) begin
                        state_d  = DONE;
                        done_now = 1'b1;
                    end else begin
                        state_d  = HIGH;
                        tmr_load = 1'b1;
                        tmr_len  = high_len_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A START arriving mid-train is dropped but remembered for the report
        if (cmd_start && (state_q == HIGH || state_q == LOW)) rejected_d = 1'b1;

        if (done_now) begin
            write_d                           = 1'b1;
            report_d                          = '0;
            report_d[RPT_TS_LSB +: 64]        = start_ts_d;
            report_d[RPT_ZERO_BIT]            = zero_flag;
            report_d[RPT_REJ_BIT]             = rejected_d;
            report_d[RPT_ABORT_BIT]           = abort_flag;
            report_d[DATA_WIDTH-1:0]          = emitted_d;
            rejected_d                        = 1'b0;
        end
    end

    // Output levels follow the next state and next idle level, so a LEVEL
    // command in any state takes effect one cycle later
    always_comb begin
        out_d  = (state_d == HIGH) ? ~idle_level_d : idle_level_d;
        busy_d = (state_d == HIGH) || (state_d == LOW);
    end

    // State and output registers
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state_q      <= IDLE;
            idle_level_q <= 1'b0;
            high_len_q   <= '0;
            low_len_q    <= '0;
            pcount_q     <= '0;
            emitted_q    <= '0;
            start_ts_q   <= '0;
            rejected_q   <= 1'b0;
            out_q        <= 1'b0;
            busy_q       <= 1'b0;
            write_q      <= 1'b0;
            report_q     <= '0;
        end else begin
            state_q      <= state_d;
            idle_level_q <= idle_level_d;
            high_len_q   <= high_len_d;
            low_len_q    <= low_len_d;
            pcount_q     <= pcount_d;
            emitted_q    <= emitted_d;
            start_ts_q   <= start_ts_d;
            rejected_q   <= rejected_d;
            out_q        <= out_d;
            busy_q       <= busy_d;
            write_q      <= write_d;
            report_q     <= report_d;
        end
    end

    assign output_sig = out_q;
    assign busy       = busy_q;
    assign write      = write_q;
    assign report_out = report_q;

endmodule

// File: tb/tb_pulse_train_generator.sv
// Scoreboard bench for pulse_train_generator: each scenario derives the
// expected waveform and report from the train parameters with plain arithmetic.
module tb_pulse_train_generator;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [63:0]  cmd_in = '0;
    logic         valid = 1'b0;
    logic [63:0]  counter = '0;
    logic         output_sig, busy, write;
    logic [127:0] report_out;

    pulse_train_generator #(.DATA_WIDTH(16), .PERIOD_WIDTH(16)) dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (rst_n),
        .cmd_in        (cmd_in),
        .valid         (valid),
        .counter       (counter),
        .output_sig    (output_sig),
        .busy          (busy),
        .write         (write),
        .report_out    (report_out)
    );

    always #5 clk = ~clk;

    typedef struct { logic out; logic bsy; } exp_t;
    typedef struct { logic [127:0] rpt; int edge_no; } rpt_t;

    exp_t exp_q[$];
    rpt_t rpt_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   edge_no = 0;

    always @(posedge clk) edge_no <= edge_no + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, req, edge_no);
        end
    endtask

    // Monitor: compares per-cycle levels and every report the DUT writes
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("output_sig", output_sig, e.out);
                chk("busy", busy, e.bsy);
            end
            if (write) begin
                if (rpt_q.size() == 0) begin
                    chk("unexpected_write", 1'b1, 1'b0);
                end else begin
                    rpt_t r;
                    r = rpt_q.pop_front();
                    chk("report_out", report_out, r.rpt);
                    chk("write_edge", edge_no, r.edge_no);
                end
            end
        end
    end

    function automatic logic [63:0] mk(input logic [1:0] op, input int h, input int l, input int n);
        logic [63:0] c;
        c = '0;
        c[63:62] = op;
        c[47:32] = h[15:0];
        c[31:16] = l[15:0];
        c[15:0]  = n[15:0];
        return c;
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // One train: LEVEL lvl0, START at offset 0, optional STOP / rejected START /
    // LEVEL at later offsets, then `gap` quiet cycles.
    task automatic run(input int h, input int l, input int n, input logic lvl0,
                       input logic [63:0] ts, input int stop_k, input int rej_k,
                       input int lev_k, input logic lev_v, input int gap);
        int hn, ln, p, end_k, cnt, start_edge;
        logic lvl, act;
        logic [127:0] r;
        hn = (h == 0) ? 1 : h;
        ln = (l == 0) ? 1 : l;
        p  = hn + ln;
        end_k = (stop_k >= 0) ? stop_k : n * p;
        cnt = 0;
        if (stop_k >= 0) begin
            for (int j = 0; j < n; j++) if (j * p + hn < stop_k) cnt++;
        end else begin
            cnt = n;
        end
        r = '0;
        r[127:64] = ts;
        r[50] = (n == 0);
        r[49] = (rej_k >= 0);
        r[48] = (stop_k >= 0);
        r[15:0] = cnt[15:0];

        @(negedge clk);
        cmd_in = {2'b11, 61'd0, lvl0}; valid = 1'b1; counter = rnd64();
        exp_q.push_back('{lvl0, 1'b0});
        lvl = lvl0;

        for (int k = 0; k <= end_k + gap; k++) begin
            @(negedge clk);
            cmd_in = '0; valid = 1'b0; counter = rnd64();
            if (k == 0) begin
                start_edge = edge_no + 1;
                rpt_q.push_back('{r, start_edge + end_k});
                cmd_in = mk(2'b01, h, l, n); valid = 1'b1; counter = ts;
            end else if (k == stop_k) begin
                cmd_in = mk(2'b10, 0, 0, 0); valid = 1'b1;
            end else if (k == rej_k) begin
                cmd_in = mk(2'b01, $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5));
                valid = 1'b1;
            end else if (k == lev_k) begin
                cmd_in = {2'b11, 61'd0, lev_v}; valid = 1'b1;
                lvl = lev_v;
            end
            act = (k < end_k) && ((k % p) < hn);
            exp_q.push_back('{lvl ^ act, (k < end_k)});
        end
        @(negedge clk);
        cmd_in = '0; valid = 1'b0;
    endtask

    initial begin
        #1;
        chk("reset_output_sig", output_sig, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_write", write, 1'b0);
        chk("reset_report", report_out, 128'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Basic train: H=2 L=3 N=4 at counter 100
        run(2, 3, 4, 1'b0, 64'd100, -1, -1, -1, 1'b0, 3);
        // STOP one cycle into the third HIGH of H=5 L=5 N=10
        run(5, 5, 10, 1'b0, 64'h1234_5678_9abc_def0, 21, -1, -1, 1'b0, 2);
        // Rejected START mid-train, then a clean run
        run(3, 2, 3, 1'b0, 64'd7, -1, 4, -1, 1'b0, 2);
        run(2, 2, 2, 1'b0, 64'd8, -1, -1, -1, 1'b0, 2);
        // Inverted idle level and zero-length phases
        run(1, 1, 2, 1'b1, 64'd9, -1, -1, -1, 1'b0, 2);
        run(0, 0, 2, 1'b1, 64'd10, -1, -1, -1, 1'b0, 2);
        // LEVEL flip during a HIGH phase
        run(3, 3, 2, 1'b0, 64'd11, -1, -1, 1, 1'b1, 2);
        // Zero pulse count
        run(3, 3, 0, 1'b0, 64'd12, -1, -1, -1, 1'b0, 2);

        // Async reset in the middle of a HIGH phase: no report expected
        @(negedge clk);
        cmd_in = {2'b11, 61'd0, 1'b0}; valid = 1'b1;
        exp_q.push_back('{1'b0, 1'b0});
        @(negedge clk);
        cmd_in = mk(2'b01, 4, 4, 3); valid = 1'b1;
        exp_q.push_back('{1'b1, 1'b1});
        @(negedge clk);
        cmd_in = '0; valid = 1'b0;
        exp_q.push_back('{1'b1, 1'b1});
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midreset_output_sig", output_sig, 1'b0);
        chk("midreset_busy", busy, 1'b0);
        chk("midreset_write", write, 1'b0);
        chk("midreset_report", report_out, 128'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run(2, 1, 2, 1'b0, 64'd55, -1, -1, -1, 1'b0, 2);

        // Randomized trains
        for (int s = 0; s < 40; s++) begin
            int h, l, n, p, end_k, stop_k, rej_k, lev_k;
            h = $urandom_range(0, 4);
            l = $urandom_range(0, 4);
            n = $urandom_range(0, 5);
            p = ((h == 0) ? 1 : h) + ((l == 0) ? 1 : l);
            stop_k = -1; rej_k = -1; lev_k = -1;
            if (n > 0 && n * p >= 2 && $urandom_range(0, 1) == 1)
                stop_k = $urandom_range(1, n * p - 1);
            end_k = (stop_k >= 0) ? stop_k : n * p;
            if (end_k >= 2 && $urandom_range(0, 2) == 0) rej_k = $urandom_range(1, end_k - 1);
            if (end_k >= 2 && $urandom_range(0, 2) == 0) lev_k = $urandom_range(1, end_k - 1);
            if (lev_k == rej_k) lev_k = -1;
            run(h, l, n, 1'($urandom_range(0, 1)), rnd64(), stop_k, rej_k, lev_k,
                1'($urandom_range(0, 1)), $urandom_range(1, 3));
        end

        repeat (4) @(negedge clk);
        chk("reports_outstanding", rpt_q.size(), 0);
        chk("levels_outstanding", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
